// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder deserializer.
// Holds the FSM state encoding and a sizing helper for the frame counter.
package bsa_pkg;

    // State encodings, kept as named constants so other blocks can decode them.
    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd1;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd2;
    localparam logic [1:0] ST_HOLD_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_HOLD  = ST_HOLD_ENC
    } bsa_state_e;

    // Width of a down-counter able to hold max(dly, wl).
    function automatic int cnt_width(input int dly, input int wl);
        int m;
        m = (dly > wl) ? dly : wl;
        if (m < 1) begin
            return 1;
        end else begin
            return $clog2(m + 1);
        end
    endfunction

endpackage

// File: rtl/bsa_cnt.sv
// Loadable down-counter with zero flag, used to time the WAIT and SHIFT phases.
// Load has priority over decrement; decrement saturates at zero.
module bsa_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    localparam logic [W-1:0] L_ONE  = W'(1);
    localparam logic [W-1:0] L_ZERO = W'(0);

    logic [W-1:0] r_cnt;

    // Count register: reload on phase entry, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= L_ZERO;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != L_ZERO)) begin
            r_cnt <= r_cnt - L_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == L_ZERO);

endmodule

// File: rtl/bsa_deser.sv
// Deserializer for a bit-serial adder: collects WL sum bits (LSB first)
// after a start pulse and an optional DLY-cycle gap, then holds the parallel
// word until the consumer handshakes.
// Optional feature: define BSA_DESER_CARRY_EN to add carry_in/carry_out so
// that {carry_out, sum} is the full WL+1-bit result.
module bsa_deser
    import bsa_pkg::*;
#(
    parameter int WL  = 4,
    parameter int DLY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          sbit,
    input  logic          out_ready,
    output logic [WL-1:0] sum,
    output logic          out_valid,
    output logic          busy
`ifdef BSA_DESER_CARRY_EN
    ,
    input  logic          carry_in,
    output logic          carry_out
`endif
);

    localparam int CW = cnt_width(DLY, WL);

    // Counter reload values: the phase ends on the edge where the counter is zero.
    localparam logic [CW-1:0] L_WAIT_LD  = CW'((DLY > 0) ? (DLY - 1) : 0);
    localparam logic [CW-1:0] L_SHIFT_LD = CW'(WL - 1);

    // A new frame enters WAIT only when there is a gap to wait out.
    localparam bsa_state_e    L_FIRST_ST = (DLY > 0) ? ST_WAIT : ST_SHIFT;
    localparam logic [CW-1:0] L_FIRST_LD = (DLY > 0) ? L_WAIT_LD : L_SHIFT_LD;

    bsa_state_e    r_state;
    logic [WL-1:0] r_sum;
    logic          r_valid;
    logic          r_busy;
`ifdef BSA_DESER_CARRY_EN
    logic          r_carry;
`endif

    logic          w_load;
    logic          w_dec;
    logic          w_zero;
    logic [CW-1:0] w_load_val;

    bsa_cnt #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Counter control: reload on every entry into WAIT or SHIFT, count down inside them.
    always_comb begin
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = L_FIRST_LD;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_load_val = L_FIRST_LD;
                end else begin
                    w_load     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = L_SHIFT_LD;
                end else begin
                    w_dec      = 1'b1;
                end
            end
            ST_SHIFT: begin
                w_dec = 1'b1;
            end
            ST_HOLD: begin
                if (out_ready && start) begin
                    w_load     = 1'b1;
                    w_load_val = L_FIRST_LD;
                end else begin
                    w_load     = 1'b0;
                end
            end
            default: begin
                w_load = 1'b0;
                w_dec  = 1'b0;
            end
        endcase
    end

    // Frame FSM with registered sum, valid, busy (and carry) outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sum   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
`ifdef BSA_DESER_CARRY_EN
            r_carry <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= L_FIRST_ST;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // sbit and start are deliberately ignored here.
                    if (w_zero) begin
                        r_state <= ST_SHIFT;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_SHIFT: begin
                    // LSB arrives first, so shift in from the top.
                    r_sum <= {sbit, r_sum[WL-1:1]};
                    if (w_zero) begin
                        r_state <= ST_HOLD;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
`ifdef BSA_DESER_CARRY_EN
                        r_carry <= carry_in;
`endif
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    // A handshake with start pending chains straight into the next frame.
                    if (r_valid && out_ready) begin
                        r_valid <= 1'b0;
                        if (start) begin
                            r_state <= L_FIRST_ST;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sum       = r_sum;
    assign out_valid = r_valid;
    assign busy      = r_busy;
`ifdef BSA_DESER_CARRY_EN
    assign carry_out = r_carry;
`endif

endmodule

// File: tb/tb_bsa_deser.sv
// Self-checking bench for bsa_deser: one instance with DLY=0, one with DLY=4.
// Expected sums come from the serial data itself (first bit = LSB) and the
// expected timing from the start edge plus DLY+WL.
module tb_bsa_deser;

    localparam int WL = 4;

    logic       clk;
    logic       rst;
    logic [1:0] start_v;
    logic [1:0] sbit_v;
    logic [1:0] rdy_v;
    logic [3:0] sum0, sum1;
    logic       valid0, valid1;
    logic       busy0, busy1;
`ifdef BSA_DESER_CARRY_EN
    logic [1:0] cin_v;
    logic       cout0, cout1;
`endif

    int n_checks;
    int n_errors;

    bsa_deser #(.WL(WL), .DLY(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start_v[0]),
        .sbit      (sbit_v[0]),
        .out_ready (rdy_v[0]),
        .sum       (sum0),
        .out_valid (valid0),
        .busy      (busy0)
`ifdef BSA_DESER_CARRY_EN
        ,
        .carry_in  (cin_v[0]),
        .carry_out (cout0)
`endif
    );

    bsa_deser #(.WL(WL), .DLY(4)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start_v[1]),
        .sbit      (sbit_v[1]),
        .out_ready (rdy_v[1]),
        .sum       (sum1),
        .out_valid (valid1),
        .busy      (busy1)
`ifdef BSA_DESER_CARRY_EN
        ,
        .carry_in  (cin_v[1]),
        .carry_out (cout1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sum_of(input int s);
        return (s != 0) ? sum1 : sum0;
    endfunction

    function automatic logic valid_of(input int s);
        return (s != 0) ? valid1 : valid0;
    endfunction

    function automatic logic busy_of(input int s);
        return (s != 0) ? busy1 : busy0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one frame starting at the current negedge. glitch_k>0 pulses start
    // before edge T+glitch_k (inside WAIT/SHIFT). rand_fill drives random
    // bits during the WAIT gap, otherwise zeros.
    task automatic run_frame(input int sel, input logic [3:0] bits, input bit rand_fill,
                             input int glitch_k, input int hold, input bit do_ack,
                             input logic [3:0] exp_sum, input string nm);
        int d;
        d = (sel != 0) ? 4 : 0;
        start_v[sel] = 1'b1;
        sbit_v[sel]  = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_v[sel] = 1'b0;
        chk({nm, "_busy_start"}, 8'(busy_of(sel)), 8'd1);
        chk({nm, "_valid_start"}, 8'(valid_of(sel)), 8'd0);
        for (int k = 1; k <= d + WL; k++) begin
            start_v[sel] = (k == glitch_k);
            if (k > d) begin
                sbit_v[sel] = bits[k - d - 1];
            end else begin
                sbit_v[sel] = rand_fill ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            if (k == d + WL - 1) begin
                chk({nm, "_valid_early"}, 8'(valid_of(sel)), 8'd0);
                chk({nm, "_busy_late"}, 8'(busy_of(sel)), 8'd1);
            end
        end
        start_v[sel] = 1'b0;
        sbit_v[sel]  = 1'($urandom_range(0, 1));
        chk({nm, "_valid"}, 8'(valid_of(sel)), 8'd1);
        chk({nm, "_busy_done"}, 8'(busy_of(sel)), 8'd0);
        chk({nm, "_sum"}, 8'(sum_of(sel)), 8'(exp_sum));
        for (int h = 0; h < hold; h++) begin
            start_v[sel] = 1'($urandom_range(0, 1));
            sbit_v[sel]  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({nm, "_hold_valid"}, 8'(valid_of(sel)), 8'd1);
            chk({nm, "_hold_sum"}, 8'(sum_of(sel)), 8'(exp_sum));
        end
        start_v[sel] = 1'b0;
        if (do_ack) begin
            rdy_v[sel] = 1'b1;
            @(negedge clk);
            rdy_v[sel] = 1'b0;
            chk({nm, "_ack_valid"}, 8'(valid_of(sel)), 8'd0);
            chk({nm, "_ack_busy"}, 8'(busy_of(sel)), 8'd0);
        end
    endtask

    typedef struct {
        int         sel;
        logic [3:0] bits;
        int         glitch;
        int         hold;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start_v  = 2'b00;
        sbit_v   = 2'b00;
        rdy_v    = 2'b00;
`ifdef BSA_DESER_CARRY_EN
        cin_v    = 2'b00;
`endif
        // bits[i] is the i-th serial bit; exp is the parallel word it must form.
        tbl[0] = '{0, 4'b1101, 0, 3, 4'b1101}; // serial 1,0,1,1
        tbl[1] = '{1, 4'b1111, 0, 1, 4'hF};    // DLY=4, zeros during WAIT
        tbl[2] = '{0, 4'b0011, 2, 0, 4'h3};    // start pulsed in SHIFT
        tbl[3] = '{1, 4'b1010, 3, 2, 4'hA};    // start pulsed in WAIT
        tbl[4] = '{1, 4'b0101, 6, 0, 4'h5};    // start pulsed in SHIFT
        tbl[5] = '{0, 4'b0000, 4, 1, 4'h0};    // start on last sample edge

        #1;
        chk("rst_sum0", 8'(sum0), 8'h0);
        chk("rst_valid0", 8'(valid0), 8'h0);
        chk("rst_busy0", 8'(busy0), 8'h0);
        chk("rst_sum1", 8'(sum1), 8'h0);
        chk("rst_busy1", 8'(busy1), 8'h0);
`ifdef BSA_DESER_CARRY_EN
        chk("rst_carry0", 8'(cout0), 8'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].sel, tbl[i].bits, 1'b0, tbl[i].glitch, tbl[i].hold,
                      1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        for (int r = 0; r < 20; r++) begin
            int         s;
            logic [3:0] b;
            int         g;
            s = int'($urandom_range(0, 1));
            b = 4'($urandom_range(0, 15));
            g = int'($urandom_range(0, (s != 0) ? 8 : 4));
            run_frame(s, b, 1'b1, g, int'($urandom_range(0, 3)), 1'b1, b,
                      $sformatf("rnd%0d", r));
        end

        // Handshake and start in the same cycle: new frame without a gap.
        run_frame(0, 4'b1101, 1'b0, 0, 1, 1'b0, 4'b1101, "b2b_a");
        rdy_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rdy_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        chk("b2b_valid_drop", 8'(valid0), 8'd0);
        chk("b2b_busy", 8'(busy0), 8'd1);
        chk("b2b_sum_kept", 8'(sum0), 8'b1101);
        for (int k = 0; k < 4; k++) begin
            sbit_v[0] = (k == 1);                  // serial 0,1,0,0
            @(negedge clk);
        end
        chk("b2b_valid", 8'(valid0), 8'd1);
        chk("b2b_sum", 8'(sum0), 8'b0010);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        rdy_v[0] = 1'b0;
        chk("b2b_ack_valid", 8'(valid0), 8'd0);

        // Reset in the middle of SHIFT after two bits.
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sbit_v[0] = 1'b1;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sum", 8'(sum0), 8'h0);
        chk("mid_rst_busy", 8'(busy0), 8'h0);
        chk("mid_rst_valid", 8'(valid0), 8'h0);
        @(negedge clk);
        rst = 1'b0;
        // Start is presented immediately so the first edge after reset takes it.
        run_frame(0, 4'b1100, 1'b0, 0, 0, 1'b1, 4'b1100, "post_rst");

`ifdef BSA_DESER_CARRY_EN
        begin
            logic [4:0] tot;
            tot = 5'h0B + 5'h06;
            start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                sbit_v[0] = tot[k];
                cin_v[0]  = (k == 3) ? tot[4] : ~tot[4];
                @(negedge clk);
            end
            cin_v[0] = 1'b0;
            chk("carry_sum", 8'(sum0), 8'h1);
            chk("carry_out", 8'(cout0), 8'h1);
            @(negedge clk);
            chk("carry_hold", 8'(cout0), 8'h1);
            rdy_v[0] = 1'b1;
            @(negedge clk);
            rdy_v[0] = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
